// File: rtl/latency_probe.sv
// latency_probe: per-message latency monitor for an N-stage pipeline.
// Start stamps live in a ring; each stage consumes them in order.
module latency_probe #(
  parameter int N_STAGES = 3,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 32,
  parameter int SUM_W    = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                start_evt,
  input  logic [N_STAGES-1:0] stage_evt,
  input  logic [(N_STAGES>1 ? $clog2(N_STAGES) : 1)-1:0] rd_sel,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    stat_count,
  output logic [CNT_W-1:0]    stat_min,
  output logic [CNT_W-1:0]    stat_max,
  output logic [SUM_W-1:0]    stat_sum,
  output logic [CNT_W-1:0]    last_delta,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                overflow,
  output logic                orphan_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ts [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp [N_STAGES];

  logic [PW-1:0]    prev_ptr [N_STAGES];
  logic [PW-1:0]    pend [N_STAGES];
  logic [N_STAGES-1:0] hit;
  logic [CNT_W-1:0] delta [N_STAGES];
  logic [SUM_W:0]   sum_ext [N_STAGES];

  logic [CNT_W-1:0] st_cnt  [N_STAGES];
  logic [CNT_W-1:0] st_min  [N_STAGES];
  logic [CNT_W-1:0] st_max  [N_STAGES];
  logic [SUM_W-1:0] st_sum  [N_STAGES];
  logic [CNT_W-1:0] st_last [N_STAGES];

  logic [PW-1:0]    used;
  logic             full;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_last;

  assign used      = wp - rp[N_STAGES-1];
  assign full      = (used == PW'(DEPTH));
  assign inflight  = used;
  assign cycle_cnt = cnt;

  // Stage s consumes what stage s-1 (or the writer) has released.
  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign prev_ptr[g] = wp;
    end else begin : g_tail
      assign prev_ptr[g] = rp[g-1];
    end
    assign pend[g]    = prev_ptr[g] - rp[g];
    assign hit[g]     = stage_evt[g] && (pend[g] != '0);
    assign delta[g]   = cnt - ts[rp[g][AW-1:0]];
    assign sum_ext[g] = {1'b0, st_sum[g]} + (SUM_W+1)'(delta[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      wp         <= '0;
      overflow   <= 1'b0;
      orphan_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ts[i] <= '0;
      for (int s = 0; s < N_STAGES; s++) begin
        rp[s]      <= '0;
        st_cnt[s]  <= '0;
        st_min[s]  <= '1;
        st_max[s]  <= '0;
        st_sum[s]  <= '0;
        st_last[s] <= '0;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (clear) begin
        wp         <= '0;
        overflow   <= 1'b0;
        orphan_err <= 1'b0;
        for (int i = 0; i < DEPTH; i++) ts[i] <= '0;
        for (int s = 0; s < N_STAGES; s++) begin
          rp[s]      <= '0;
          st_cnt[s]  <= '0;
          st_min[s]  <= '1;
          st_max[s]  <= '0;
          st_sum[s]  <= '0;
          st_last[s] <= '0;
        end
      end else begin
        if (start_evt) begin
          if (full) begin
            overflow <= 1'b1;
          end else begin
            ts[wp[AW-1:0]] <= cnt;
            wp             <= wp + PW'(1);
          end
        end
        for (int s = 0; s < N_STAGES; s++) begin
          if (stage_evt[s] && !hit[s]) orphan_err <= 1'b1;
          if (hit[s]) begin
            rp[s]      <= rp[s] + PW'(1);
            st_last[s] <= delta[s];
            if (~&st_cnt[s]) st_cnt[s] <= st_cnt[s] + CNT_W'(1);
            if (delta[s] < st_min[s]) st_min[s] <= delta[s];
            if (delta[s] > st_max[s]) st_max[s] <= delta[s];
            if (sum_ext[s][SUM_W]) st_sum[s] <= '1;
            else st_sum[s] <= sum_ext[s][SUM_W-1:0];
          end
        end
      end
    end
  end

  // Out-of-range selects fall through to the reset pattern.
  always_comb begin
    r_cnt  = '0;
    r_min  = '1;
    r_max  = '0;
    r_sum  = '0;
    r_last = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (rd_sel == SW'(s)) begin
        r_cnt  = st_cnt[s];
        r_min  = st_min[s];
        r_max  = st_max[s];
        r_sum  = st_sum[s];
        r_last = st_last[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= '0;
      stat_min   <= '1;
      stat_max   <= '0;
      stat_sum   <= '0;
      last_delta <= '0;
    end else if (clear) begin
      stat_count <= '0;
      stat_min   <= '1;
      stat_max   <= '0;
      stat_sum   <= '0;
      last_delta <= '0;
    end else begin
      stat_count <= r_cnt;
      stat_min   <= r_min;
      stat_max   <= r_max;
      stat_sum   <= r_sum;
      last_delta <= r_last;
    end
  end

endmodule
